// File: rtl/converter_pkg.sv
// converter_pkg: shared mode encoding and default widths for the code converters
package converter_pkg;
    localparam int DEF_IN_W  = 3;
    localparam int DEF_OUT_W = 4;
    localparam int DEF_CNT_W = 8;
    typedef enum logic {
        MODE_LOOKUP = 1'b0,
        MODE_BYPASS = 1'b1
    } mode_e;
endpackage

// File: rtl/lut_converter_if.sv
// lut_converter_if: valid/ready code stream, input and output sides of the converter
interface lut_converter_if
    import converter_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  data_i;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] data_o;
    modport master (output in_valid, data_i, out_ready, input in_ready, out_valid, data_o);
    modport slave  (input in_valid, data_i, out_ready, output in_ready, out_valid, data_o);
endinterface

// File: rtl/lut_table_regs.sv
// lut_table_regs: register-array lookup table, sync write, comb read, identity on reset
module lut_table_regs
    import converter_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IN_W-1:0]  wr_addr,
    input  logic [OUT_W-1:0] wr_data,
    input  logic [IN_W-1:0]  rd_addr,
    output logic [OUT_W-1:0] rd_data
);
    logic [OUT_W-1:0] mem [2**IN_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**IN_W; i++) mem[i] <= OUT_W'(i);
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/lut_converter.sv
// lut_converter: programmable code converter with registered output, bypass and saturating count
module lut_converter
    import converter_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              cfg_we,
    input  logic [IN_W-1:0]   cfg_addr,
    input  logic [OUT_W-1:0]  cfg_data,
    output logic [CNT_W-1:0]  conv_count,
    lut_converter_if.slave    bus
);
    logic [OUT_W-1:0] lut_val;
    logic             accept;

    lut_table_regs #(.IN_W(IN_W), .OUT_W(OUT_W)) u_table (
        .clk     (clk),
        .rst     (rst),
        .we      (cfg_we),
        .wr_addr (cfg_addr),
        .wr_data (cfg_data),
        .rd_addr (bus.data_i),
        .rd_data (lut_val)
    );

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // The table read is taken before any same-edge write lands, so a colliding lookup sees the old entry
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.data_o    <= '0;
            conv_count    <= '0;
        end else begin
            if (accept) begin
                bus.data_o    <= (mode == MODE_BYPASS) ? OUT_W'(bus.data_i) : lut_val;
                bus.out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (accept && conv_count != {CNT_W{1'b1}}) conv_count <= conv_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_lut_converter.sv
// tb_lut_converter: directed scenario tests for lut_converter, including a CNT_W=3 twin for saturation
module tb_lut_converter;
    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [3:0] cfg_data;
    logic [7:0] conv_a;
    logic [2:0] conv_b;
    int         tests = 0;
    int         fails = 0;

    lut_converter_if #(.IN_W(3), .OUT_W(4)) ia ();
    lut_converter_if #(.IN_W(3), .OUT_W(4)) ib ();

    assign ib.in_valid  = ia.in_valid;
    assign ib.data_i    = ia.data_i;
    assign ib.out_ready = ia.out_ready;

    lut_converter #(.IN_W(3), .OUT_W(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .mode(mode), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .conv_count(conv_a), .bus(ia.slave)
    );

    lut_converter #(.IN_W(3), .OUT_W(4), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .mode(mode), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .conv_count(conv_b), .bus(ib.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        tests++; if (ia.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0h exp 0", ia.out_valid); end
        tests++; if (ia.data_o !== 4'd0) begin fails++; $display("FAIL reset_data_o got %0h exp 0", ia.data_o); end
        tests++; if (conv_a !== 8'd0) begin fails++; $display("FAIL reset_conv_count got %0d exp 0", conv_a); end
        tests++; if (ia.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0h exp 1", ia.in_ready); end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 8; i++) begin
            ia.data_i = 3'(i);
            ia.in_valid = 1'b1;
            step();
            tests++; if (ia.out_valid !== 1'b1 || ia.data_o !== 4'(i)) begin fails++; $display("FAIL stream_%0d got v=%0h d=%0h exp v=1 d=%0h", i, ia.out_valid, ia.data_o, i); end
        end
        ia.in_valid = 1'b0;
        step();
        tests++; if (ia.out_valid !== 1'b0 || ia.data_o !== 4'd7) begin fails++; $display("FAIL stream_drain got v=%0h d=%0h exp v=0 d=7", ia.out_valid, ia.data_o); end
        tests++; if (conv_a !== 8'd8) begin fails++; $display("FAIL stream_count got %0d exp 8", conv_a); end
        tests++; if (conv_b !== 3'd7) begin fails++; $display("FAIL stream_sat_count got %0d exp 7", conv_b); end
    endtask

    task automatic test_reprogram();
        logic [2:0] addrs [4] = '{3'd1, 3'd3, 3'd7, 3'd5};
        logic [3:0] exps  [4] = '{4'd8, 4'd2, 4'd9, 4'd5};
        cfg_we = 1'b1;
        cfg_addr = 3'd1; cfg_data = 4'd8; step();
        cfg_addr = 3'd3; cfg_data = 4'd2; step();
        cfg_addr = 3'd7; cfg_data = 4'd9; step();
        cfg_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ia.data_i = addrs[i];
            ia.in_valid = 1'b1;
            step();
            tests++; if (ia.data_o !== exps[i]) begin fails++; $display("FAIL reprog_in%0d got %0h exp %0h", addrs[i], ia.data_o, exps[i]); end
        end
        ia.in_valid = 1'b0;
        step();
        tests++; if (conv_a !== 8'd12) begin fails++; $display("FAIL reprog_count got %0d exp 12", conv_a); end
    endtask

    task automatic test_backpressure();
        ia.out_ready = 1'b0;
        ia.data_i = 3'd1;
        ia.in_valid = 1'b1;
        step();
        tests++; if (ia.out_valid !== 1'b1 || ia.data_o !== 4'd8) begin fails++; $display("FAIL bp_load got v=%0h d=%0h exp v=1 d=8", ia.out_valid, ia.data_o); end
        ia.data_i = 3'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++; if (ia.out_valid !== 1'b1 || ia.data_o !== 4'd8 || ia.in_ready !== 1'b0 || conv_a !== 8'd13) begin
                fails++; $display("FAIL bp_hold_%0d got v=%0h d=%0h rdy=%0h cnt=%0d exp v=1 d=8 rdy=0 cnt=13", i, ia.out_valid, ia.data_o, ia.in_ready, conv_a);
            end
        end
        ia.out_ready = 1'b1;
        #1;
        tests++; if (ia.in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %0h exp 1", ia.in_ready); end
        step();
        tests++; if (ia.out_valid !== 1'b1 || ia.data_o !== 4'd2 || conv_a !== 8'd14) begin fails++; $display("FAIL bp_pop_accept got v=%0h d=%0h cnt=%0d exp v=1 d=2 cnt=14", ia.out_valid, ia.data_o, conv_a); end
        ia.in_valid = 1'b0;
        step();
    endtask

    task automatic test_collision();
        cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = 4'd5;
        step();
        cfg_data = 4'd6;
        ia.data_i = 3'd2;
        ia.in_valid = 1'b1;
        step();
        tests++; if (ia.data_o !== 4'd5) begin fails++; $display("FAIL collision_old got %0h exp 5", ia.data_o); end
        cfg_we = 1'b0;
        step();
        tests++; if (ia.data_o !== 4'd6) begin fails++; $display("FAIL collision_new got %0h exp 6", ia.data_o); end
        ia.in_valid = 1'b0;
        step();
    endtask

    task automatic test_bypass_sat();
        mode = 1'b1;
        ia.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ia.data_i = 3'((7 + i) % 8);
            step();
            tests++; if (ia.data_o !== 4'((7 + i) % 8)) begin fails++; $display("FAIL bypass_%0d got %0h exp %0h", i, ia.data_o, (7 + i) % 8); end
        end
        ia.in_valid = 1'b0;
        step();
        tests++; if (conv_b !== 3'd7) begin fails++; $display("FAIL sat_count got %0d exp 7", conv_b); end
        tests++; if (conv_a !== 8'd26) begin fails++; $display("FAIL bypass_count got %0d exp 26", conv_a); end
        mode = 1'b0;
    endtask

    task automatic test_reset_mid();
        ia.out_ready = 1'b0;
        ia.data_i = 3'd1;
        ia.in_valid = 1'b1;
        step();
        tests++; if (ia.out_valid !== 1'b1 || ia.data_o !== 4'd8) begin fails++; $display("FAIL mid_load got v=%0h d=%0h exp v=1 d=8", ia.out_valid, ia.data_o); end
        ia.in_valid = 1'b0;
        rst = 1'b1;
        cfg_we = 1'b1; cfg_addr = 3'd3; cfg_data = 4'd12;
        step();
        tests++; if (ia.out_valid !== 1'b0 || ia.data_o !== 4'd0 || conv_a !== 8'd0 || ia.in_ready !== 1'b1) begin
            fails++; $display("FAIL mid_reset got v=%0h d=%0h cnt=%0d rdy=%0h exp v=0 d=0 cnt=0 rdy=1", ia.out_valid, ia.data_o, conv_a, ia.in_ready);
        end
        rst = 1'b0;
        cfg_we = 1'b0;
        ia.out_ready = 1'b1;
        ia.in_valid = 1'b1;
        ia.data_i = 3'd3;
        step();
        tests++; if (ia.data_o !== 4'd3) begin fails++; $display("FAIL mid_identity3 got %0h exp 3", ia.data_o); end
        ia.data_i = 3'd1;
        step();
        tests++; if (ia.data_o !== 4'd1 || conv_a !== 8'd2) begin fails++; $display("FAIL mid_identity1 got d=%0h cnt=%0d exp d=1 cnt=2", ia.data_o, conv_a); end
        ia.in_valid = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        ia.in_valid = 1'b0; ia.data_i = '0; ia.out_ready = 1'b1;
        test_reset();
        test_stream();
        test_reprogram();
        test_backpressure();
        test_collision();
        test_bypass_sat();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/lut_converter.md
Name: lut_converter

Overview:
Parametrised, run-time programmable code converter. It maps an IN_W-bit input code to an OUT_W-bit output code through a writable lookup table, with a one-stage registered output and a valid/ready handshake on both sides. It is the streaming successor to the team's fixed combinational code converters and sits between a code source (counter, keypad or FSM) and a display/decoder stage. It also provides a bypass mode and a saturating conversion counter.

Parameters:
IN_W, 3, input code width; the table has 2**IN_W entries
OUT_W, 4, output code width
CNT_W, 8, width of the conversion counter

Ports:
clk  input  1  clock; all state updates on its rising edge
rst  input  1  reset, synchronous, active-high
mode  input  1  0 = lookup through table; 1 = bypass
in_valid  input  1  input code valid
in_ready  output  1  block can accept an input this cycle
data_i  input  IN_W  input code
out_valid  output  1  data_o holds a converted code
out_ready  input  1  downstream accepts data_o this cycle
data_o  output  OUT_W  converted code
cfg_we  input  1  table write enable
cfg_addr  input  IN_W  table entry to write
cfg_data  input  OUT_W  value to write
conv_count  output  CNT_W  number of accepted conversions, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, data_o=0, conv_count=0.
- Reset table contents: entry i = i, truncated or zero-extended to OUT_W.
- Reset mid-operation: any pending output is dropped. All cfg writes made before reset are lost.
- in_ready = !out_valid || out_ready. This is combinational, and in_ready is 1 during reset.
- Accept condition: in_valid && in_ready, sampled at the clock edge.
- On accept:
  - data_o <= table[data_i] when mode=0; data_i truncated or zero-extended to OUT_W when mode=1.
  - out_valid <= 1.
- Latency: one cycle from accept to out_valid=1.
- Throughput: one code per cycle while out_ready=1.
- Pop without new accept (out_valid && out_ready && !accept): out_valid <= 0. data_o keeps its last value.
- Back-pressure (out_valid && !out_ready): data_o and out_valid hold. in_ready=0, so no input is accepted.
- mode is sampled only at accept. Changing mode while an output is held does not alter data_o.
- Table write: when cfg_we=1, table[cfg_addr] <= cfg_data at the edge. Writes are allowed in any cycle, regardless of handshake state.
- Same-cycle write and lookup of the same entry: the lookup returns the OLD entry value. The new value is visible from the next accept.
- cfg_we during rst: ignored, reset wins.
- conv_count: increments by 1 on every accept, in both modes. It saturates at 2**CNT_W-1 and does not wrap. It is cleared only by rst.
- No X-propagation is allowed. Every table entry is defined from reset.

Decomposition:
- Shared package/include converter_pkg:
  - MODE_LOOKUP=1'b0, MODE_BYPASS=1'b1.
  - Default widths IN_W, OUT_W, CNT_W.
- One sub-module, lut_table_regs:
  - 2**IN_W x OUT_W register array.
  - Synchronous write port and combinational read port.
  - Synchronous reset to the identity pattern.
- The top level holds the output register, the handshake logic and the saturating counter.

Test Plan:
- Reset then stream: stream 0..7 in lookup mode with out_ready=1 -> data_o = 0..7, one per cycle, one-cycle latency, conv_count=8.
- Reprogram table: write table[1]=8, [3]=2, [7]=9, then input 1,3,7 -> data_o 8,2,9. Input 5 -> 5 (unwritten entry).
- Back-pressure: out_ready=0 for 3 cycles with out_valid=1, data_o=8 -> data_o holds 8, in_ready=0, no accept, conv_count unchanged. Raise out_ready -> pop, next input accepted in the same cycle.
- Write/read collision: table[2]=5, then in the same cycle accept data_i=2 and write cfg_addr=2, cfg_data=6 -> data_o=5. The next accept of 2 -> 6.
- Bypass and saturation (CNT_W=3): mode=1, input 7 -> data_o=7. Perform 10 accepts -> conv_count stops at 7.
- Reset mid-operation: rst asserted while out_valid=1 and out_ready=0 -> out_valid=0, data_o=0, conv_count=0, table back to identity, and input 3 then yields 3.
